// File: rtl/p405s_icu_fill_buf_if.sv
// Bus bundle between the ICU control/fetch logic and the line-fill buffer.
// The fill source and fetch requester use the master side; the buffer uses the slave side.
interface p405s_icu_fill_buf_if #(
  parameter int WORDS = 8,
  parameter int DW    = 32
);
  localparam int IW = $clog2(WORDS);

  logic            fillStart;
  logic [IW-1:0]   fillWordIdx;
  logic            fillDataValid;
  logic [0:DW-1]   fillData;
  logic            fillAbort;
  logic            reqValid;
  logic [IW-1:0]   reqWordIdx;
  logic [0:DW-1]   fetchData;
  logic            fetchEn;
  logic            fillBusy;
  logic            fillDone;
  logic [WORDS-1:0] wordValid;
  logic [IW-1:0]   curPtr;

  modport master (
    output fillStart, fillWordIdx, fillDataValid, fillData, fillAbort,
    output reqValid, reqWordIdx,
    input  fetchData, fetchEn, fillBusy, fillDone, wordValid, curPtr
  );

  modport slave (
    input  fillStart, fillWordIdx, fillDataValid, fillData, fillAbort,
    input  reqValid, reqWordIdx,
    output fetchData, fetchEn, fillBusy, fillDone, wordValid, curPtr
  );
endinterface

// File: rtl/p405s_icu_fill_buf.sv
// ICU line-fill buffer: gathers a critical-word-first wrapping line fill and
// forwards already-present words to the fetch register one cycle after request.
module p405s_icu_fill_buf #(
  parameter int WORDS = 8,
  parameter int DW    = 32
) (
  input  logic                  CB,
  input  logic                  reset,
  p405s_icu_fill_buf_if.slave   bus
);
  localparam int IW = $clog2(WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [WORDS-1:0] wordValid_q, wordValid_d;
  logic [IW-1:0]    curPtr_q, curPtr_d;
  logic [IW-1:0]    count_q, count_d;
  logic [0:DW-1]    fetchData_q, fetchData_d;
  logic             fetchEn_q, fetchEn_d;
  logic [0:DW-1]    lineBuf_q [WORDS];

  logic wrEn;
  logic bypass;
  logic hit;

  // An aborted beat is never written, so it can neither update the line nor be bypassed.
  always_comb begin
    wrEn   = (state_q == FILL) && bus.fillDataValid && !bus.fillAbort;
    bypass = wrEn && (curPtr_q == bus.reqWordIdx);
    hit    = bus.reqValid && (wordValid_q[bus.reqWordIdx] || bypass);

    fetchEn_d   = hit;
    fetchData_d = fetchData_q;
    if (hit) begin
      fetchData_d = bypass ? bus.fillData : lineBuf_q[bus.reqWordIdx];
    end
  end

  always_comb begin
    state_d     = state_q;
    wordValid_d = wordValid_q;
    curPtr_d    = curPtr_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (bus.fillStart) begin
          wordValid_d = '0;
          curPtr_d    = bus.fillWordIdx;
          count_d     = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (bus.fillAbort) begin
          wordValid_d = '0;
          state_d     = IDLE;
        end else if (bus.fillDataValid) begin
          wordValid_d[curPtr_q] = 1'b1;
          curPtr_d              = curPtr_q + 1'b1;
          count_d               = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CB) begin
    if (reset) begin
      state_q     <= IDLE;
      wordValid_q <= '0;
      curPtr_q    <= '0;
      count_q     <= '0;
      fetchData_q <= '0;
      fetchEn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordValid_q <= wordValid_d;
      curPtr_q    <= curPtr_d;
      count_q     <= count_d;
      fetchData_q <= fetchData_d;
      fetchEn_q   <= fetchEn_d;
    end
  end

  // Line storage needs no reset: wordValid gates every read.
  always_ff @(posedge CB) begin
    if (wrEn) begin
      lineBuf_q[curPtr_q] <= bus.fillData;
    end
  end

  assign bus.fetchData = fetchData_q;
  assign bus.fetchEn   = fetchEn_q;
  assign bus.fillBusy  = (state_q == FILL);
  assign bus.fillDone  = (state_q == DONE);
  assign bus.wordValid = wordValid_q;
  assign bus.curPtr    = curPtr_q;

endmodule

// File: tb/tb_p405s_icu_fill_buf.sv
// Directed bench for the ICU line-fill buffer; fetch responses are checked by a
// scoreboard monitor, fill status by direct comparisons after each clock.
module tb_p405s_icu_fill_buf;
  logic CB;
  logic reset;

  p405s_icu_fill_buf_if #(.WORDS(8), .DW(32)) bus ();

  p405s_icu_fill_buf #(.WORDS(8), .DW(32)) dut (
    .CB    (CB),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] expQ [$];

  initial CB = 1'b0;
  always #5 CB = ~CB;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every fetchEn pulse must match the oldest outstanding expected hit.
  always @(negedge CB) begin
    if (bus.fetchEn === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpectedFetchEn: got data 0x%08h, expected no response",
                 bus.fetchData);
      end else begin
        logic [31:0] exp;
        exp = expQ.pop_front();
        if (bus.fetchData === exp) begin
          passes++;
        end else begin
          $display("[TB] FAIL fetchData: got 0x%08h, expected 0x%08h", bus.fetchData, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  task automatic applyStimulus();
    bus.fillStart     = 1'b0;
    bus.fillWordIdx   = '0;
    bus.fillDataValid = 1'b0;
    bus.fillData      = '0;
    bus.fillAbort     = 1'b0;
    bus.reqValid      = 1'b0;
    bus.reqWordIdx    = '0;
  endtask

  initial begin
    applyStimulus();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rstWordValid", 32'(bus.wordValid), 32'h0);
    checkOutput("rstCurPtr",    32'(bus.curPtr),    32'h0);
    checkOutput("rstBusy",      32'(bus.fillBusy),  32'h0);
    checkOutput("rstDone",      32'(bus.fillDone),  32'h0);
    checkOutput("rstFetchEn",   32'(bus.fetchEn),   32'h0);
    checkOutput("rstFetchData", bus.fetchData,      32'h0);

    // Reset in the middle of a fill
    bus.fillStart = 1'b1; bus.fillWordIdx = 3'd5;
    tick();
    applyStimulus();
    checkOutput("midStartBusy", 32'(bus.fillBusy), 32'h1);
    checkOutput("midStartPtr",  32'(bus.curPtr),   32'h5);
    for (int n = 0; n < 3; n++) begin
      bus.fillDataValid = 1'b1;
      bus.fillData      = 32'hA0000005 + 32'(n);
      tick();
    end
    applyStimulus();
    checkOutput("midWordValid", 32'(bus.wordValid), 32'hE0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midRstWordValid", 32'(bus.wordValid), 32'h0);
    checkOutput("midRstBusy",      32'(bus.fillBusy),  32'h0);
    checkOutput("midRstFetchEn",   32'(bus.fetchEn),   32'h0);
    checkOutput("midRstCurPtr",    32'(bus.curPtr),    32'h0);
    bus.reqValid = 1'b1; bus.reqWordIdx = 3'd5;
    tick();
    applyStimulus();
    checkOutput("midRstReqMiss", 32'(bus.fetchEn), 32'h0);

    // Critical-word-first fill starting at index 6, wrapping through 7 -> 0
    bus.fillStart = 1'b1; bus.fillWordIdx = 3'd6;
    tick();
    applyStimulus();
    checkOutput("wrapStartPtr", 32'(bus.curPtr), 32'h6);
    for (int n = 0; n < 8; n++) begin
      bus.fillDataValid = 1'b1;
      bus.fillData      = 32'h10000000 + 32'(n);
      tick();
      checkOutput($sformatf("wrapPtr%0d", n), 32'(bus.curPtr), 32'((6 + n + 1) % 8));
      if (n < 7) begin
        checkOutput($sformatf("wrapBusy%0d", n), 32'(bus.fillBusy), 32'h1);
        checkOutput($sformatf("wrapDone%0d", n), 32'(bus.fillDone), 32'h0);
      end
    end
    applyStimulus();
    checkOutput("wrapDone",      32'(bus.fillDone),  32'h1);
    checkOutput("wrapBusyDrop",  32'(bus.fillBusy),  32'h0);
    checkOutput("wrapWordValid", 32'(bus.wordValid), 32'hFF);

    // fillStart during DONE is ignored
    bus.fillStart = 1'b1; bus.fillWordIdx = 3'd3;
    tick();
    applyStimulus();
    checkOutput("doneStartBusy",  32'(bus.fillBusy),  32'h0);
    checkOutput("doneStartDone",  32'(bus.fillDone),  32'h0);
    checkOutput("doneStartPtr",   32'(bus.curPtr),    32'h6);
    checkOutput("doneStartValid", 32'(bus.wordValid), 32'hFF);

    // fillDataValid in IDLE is ignored
    bus.fillDataValid = 1'b1; bus.fillData = 32'h0BAD0BAD;
    tick();
    applyStimulus();
    checkOutput("idleBeatPtr",   32'(bus.curPtr),    32'h6);
    checkOutput("idleBeatValid", 32'(bus.wordValid), 32'hFF);

    // Back-to-back reads of the completed line: index i holds beat (i+2)%8
    for (int i = 0; i < 8; i++) begin
      bus.reqValid   = 1'b1;
      bus.reqWordIdx = 3'(i);
      expQ.push_back(32'h10000000 + 32'((i + 2) % 8));
      tick();
    end
    applyStimulus();
    tick();

    // Early restart: the request for the first beat is served by bypass
    bus.fillStart = 1'b1; bus.fillWordIdx = 3'd2;
    tick();
    applyStimulus();
    bus.fillDataValid = 1'b1; bus.fillData = 32'hDEADBEEF;
    bus.reqValid = 1'b1; bus.reqWordIdx = 3'd2;
    expQ.push_back(32'hDEADBEEF);
    tick();
    applyStimulus();

    // Miss on index 4; fillStart during FILL ignored
    bus.reqValid = 1'b1; bus.reqWordIdx = 3'd4;
    bus.fillStart = 1'b1; bus.fillWordIdx = 3'd0;
    tick();
    applyStimulus();
    checkOutput("missFetchEn",    32'(bus.fetchEn),   32'h0);
    checkOutput("missHoldData",   bus.fetchData,      32'hDEADBEEF);
    checkOutput("fillStartPtr",   32'(bus.curPtr),    32'h3);
    checkOutput("fillStartValid", 32'(bus.wordValid), 32'h04);
    bus.fillDataValid = 1'b1; bus.fillData = 32'h33333333;
    tick();
    bus.fillData = 32'h44444444;
    tick();
    applyStimulus();
    bus.reqValid = 1'b1; bus.reqWordIdx = 3'd4;
    expQ.push_back(32'h44444444);
    tick();
    applyStimulus();
    checkOutput("hitWordValid", 32'(bus.wordValid), 32'h1C);

    // Abort with a simultaneous beat; same-cycle request sees pre-abort validity
    bus.fillAbort = 1'b1;
    bus.fillDataValid = 1'b1; bus.fillData = 32'h55555555;
    bus.reqValid = 1'b1; bus.reqWordIdx = 3'd3;
    expQ.push_back(32'h33333333);
    tick();
    applyStimulus();
    checkOutput("abortBusy",  32'(bus.fillBusy),  32'h0);
    checkOutput("abortValid", 32'(bus.wordValid), 32'h0);
    checkOutput("abortDone",  32'(bus.fillDone),  32'h0);
    bus.fillStart = 1'b1; bus.fillWordIdx = 3'd1;
    bus.reqValid = 1'b1; bus.reqWordIdx = 3'd3;
    tick();
    applyStimulus();
    checkOutput("postAbortMiss",  32'(bus.fetchEn),  32'h0);
    checkOutput("restartBusy",    32'(bus.fillBusy), 32'h1);
    checkOutput("restartPtr",     32'(bus.curPtr),   32'h1);

    tick();
    tick();
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
